// File: rtl/e203_dtcm_arb_pkg.sv
// Shared types and constants for the DTCM SRAM arbiter.
package e203_dtcm_arb_pkg;

    typedef enum logic [1:0] {
        StActive = 2'd0,
        StSleep  = 2'd1,
        StWake   = 2'd2
    } arb_state_e;

    // Requester indices used for grant and response ownership.
    localparam int unsigned M_LSU = 0;
    localparam int unsigned M_EXT = 1;

endpackage

// File: rtl/e203_dtcm_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances on accept.
module e203_dtcm_rr_arb2
    import e203_dtcm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    // Index of the requester granted by the last accepted command.
    logic last_q;

    // Sole requester wins; on a tie the one not granted last wins.
    always_comb begin
        gnt_idx_o = 1'(M_LSU);
        unique case (req_i)
            2'b01:   gnt_idx_o = 1'(M_LSU);
            2'b10:   gnt_idx_o = 1'(M_EXT);
            2'b11:   gnt_idx_o = ~last_q;
            default: gnt_idx_o = 1'(M_LSU);
        endcase
        gnt_o = '0;
        if (req_i != 2'b00) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    // Reset value makes the LSU win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'(M_EXT);
        end else if (accept_i) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/e203_dtcm_ram_arb.sv
// Shares the single-ported DTCM SRAM between the LSU (m0) and the external ICB (m1),
// absorbing the one-cycle read latency and managing SRAM light sleep.
module e203_dtcm_ram_arb
    import e203_dtcm_arb_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned MW       = 4,
    parameter int unsigned AW       = 16,
    parameter int unsigned RAM_AW   = 14,
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lp_en_i,

    input  logic              m0_cmd_valid_i,
    output logic              m0_cmd_ready_o,
    input  logic [AW-1:0]     m0_cmd_addr_i,
    input  logic              m0_cmd_read_i,
    input  logic [DW-1:0]     m0_cmd_wdata_i,
    input  logic [MW-1:0]     m0_cmd_wmask_i,
    output logic              m0_rsp_valid_o,
    input  logic              m0_rsp_ready_i,
    output logic [DW-1:0]     m0_rsp_rdata_o,

    input  logic              m1_cmd_valid_i,
    output logic              m1_cmd_ready_o,
    input  logic [AW-1:0]     m1_cmd_addr_i,
    input  logic              m1_cmd_read_i,
    input  logic [DW-1:0]     m1_cmd_wdata_i,
    input  logic [MW-1:0]     m1_cmd_wmask_i,
    output logic              m1_rsp_valid_o,
    input  logic              m1_rsp_ready_i,
    output logic [DW-1:0]     m1_rsp_rdata_o,

    output logic              ram_sd_o,
    output logic              ram_ds_o,
    output logic              ram_ls_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [MW-1:0]     ram_wem_o,
    output logic [DW-1:0]     ram_din_o,
    input  logic [DW-1:0]     ram_dout_i
);

    localparam int unsigned CntW = $clog2(IDLE_CYC + 1);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic            rsp_pend_q, rsp_pend_d;   // a response is outstanding
    logic            owner_q, owner_d;         // requester that owns the response
    logic            read_q, read_d;           // outstanding command was a read
    logic            first_q, first_d;         // first response cycle: data straight from SRAM
    logic [DW-1:0]   buf_q, buf_d;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            gnt_idx;
    logic            owner_rsp_ready;
    logic            rsp_fire;
    logic            cmd_ok;
    logic            cmd_fire;
    logic            win_read;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic [MW-1:0]   win_wmask;
    logic [DW-1:0]   rsp_data;
    logic            unused_addr;

    assign req = {m1_cmd_valid_i, m0_cmd_valid_i};

    e203_dtcm_rr_arb2 u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .accept_i  (cmd_fire),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Handshake qualification and winner command mux.
    always_comb begin
        owner_rsp_ready = (owner_q == 1'(M_EXT)) ? m1_rsp_ready_i : m0_rsp_ready_i;
        rsp_fire        = rsp_pend_q && owner_rsp_ready;
        // Gated by rst_n so no strobe escapes while reset is held.
        cmd_ok          = rst_n && (state_q == StActive) && (!rsp_pend_q || owner_rsp_ready);
        cmd_fire        = (|req) && cmd_ok;
        m0_cmd_ready_o  = cmd_ok && gnt[M_LSU];
        m1_cmd_ready_o  = cmd_ok && gnt[M_EXT];

        win_read  = (gnt_idx == 1'(M_EXT)) ? m1_cmd_read_i  : m0_cmd_read_i;
        win_addr  = (gnt_idx == 1'(M_EXT)) ? m1_cmd_addr_i  : m0_cmd_addr_i;
        win_wdata = (gnt_idx == 1'(M_EXT)) ? m1_cmd_wdata_i : m0_cmd_wdata_i;
        win_wmask = (gnt_idx == 1'(M_EXT)) ? m1_cmd_wmask_i : m0_cmd_wmask_i;
    end

    assign unused_addr = ^win_addr[1:0];

    // SRAM strobes, held at zero unless a command is accepted this cycle.
    always_comb begin
        ram_sd_o   = 1'b0;
        ram_ds_o   = 1'b0;
        ram_ls_o   = (state_q == StSleep);
        ram_cs_o   = cmd_fire;
        ram_we_o   = cmd_fire && !win_read;
        ram_wem_o  = (cmd_fire && !win_read) ? win_wmask : '0;
        ram_addr_o = cmd_fire ? win_addr[2 +: RAM_AW] : '0;
        ram_din_o  = cmd_fire ? win_wdata : '0;
    end

    // Response path: live SRAM data in the first cycle, buffered copy afterwards.
    always_comb begin
        rsp_data       = first_q ? (read_q ? ram_dout_i : '0) : buf_q;
        m0_rsp_valid_o = rsp_pend_q && (owner_q == 1'(M_LSU));
        m1_rsp_valid_o = rsp_pend_q && (owner_q == 1'(M_EXT));
        m0_rsp_rdata_o = m0_rsp_valid_o ? rsp_data : '0;
        m1_rsp_rdata_o = m1_rsp_valid_o ? rsp_data : '0;
    end

    // Next-state for the outstanding transaction and its data buffer.
    always_comb begin
        rsp_pend_d = rsp_pend_q;
        owner_d    = owner_q;
        read_d     = read_q;
        first_d    = 1'b0;
        buf_d      = buf_q;
        // SRAM output is only valid for one cycle; keep it if the owner stalls.
        if (first_q && !owner_rsp_ready) begin
            buf_d = read_q ? ram_dout_i : '0;
        end
        if (rsp_fire) begin
            rsp_pend_d = 1'b0;
        end
        if (cmd_fire) begin
            rsp_pend_d = 1'b1;
            owner_d    = gnt_idx;
            read_d     = win_read;
            first_d    = 1'b1;
        end
    end

    // Idle counter and power-state FSM next-state.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if ((state_q != StActive) || cmd_fire) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CntW'(IDLE_CYC)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StActive: begin
                if (lp_en_i && (idle_cnt_d == CntW'(IDLE_CYC)) && !rsp_pend_q) begin
                    state_d = StSleep;
                end
            end
            StSleep: begin
                if (!lp_en_i || (|req)) begin
                    state_d = StWake;
                end
            end
            StWake:  state_d = StActive;
            default: state_d = StActive;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StActive;
            idle_cnt_q <= '0;
            rsp_pend_q <= 1'b0;
            owner_q    <= 1'(M_LSU);
            read_q     <= 1'b0;
            first_q    <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            owner_q    <= owner_d;
            read_q     <= read_d;
            first_q    <= first_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_e203_dtcm_ram_arb.sv
// Self-checking bench for e203_dtcm_ram_arb: vector table plus directed sequences.
module tb_e203_dtcm_ram_arb;

    localparam int DW = 32;
    localparam int MW = 4;
    localparam int AW = 16;
    localparam int RAM_AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, lp_en;
    logic              m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready;
    logic [AW-1:0]     m0_cmd_addr;
    logic [DW-1:0]     m0_cmd_wdata, m0_rsp_rdata;
    logic [MW-1:0]     m0_cmd_wmask;
    logic              m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready;
    logic [AW-1:0]     m1_cmd_addr;
    logic [DW-1:0]     m1_cmd_wdata, m1_rsp_rdata;
    logic [MW-1:0]     m1_cmd_wmask;
    logic              ram_sd, ram_ds, ram_ls, ram_cs, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [MW-1:0]     ram_wem;
    logic [DW-1:0]     ram_din, ram_dout;

    e203_dtcm_ram_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lp_en_i        (lp_en),
        .m0_cmd_valid_i (m0_cmd_valid),
        .m0_cmd_ready_o (m0_cmd_ready),
        .m0_cmd_addr_i  (m0_cmd_addr),
        .m0_cmd_read_i  (m0_cmd_read),
        .m0_cmd_wdata_i (m0_cmd_wdata),
        .m0_cmd_wmask_i (m0_cmd_wmask),
        .m0_rsp_valid_o (m0_rsp_valid),
        .m0_rsp_ready_i (m0_rsp_ready),
        .m0_rsp_rdata_o (m0_rsp_rdata),
        .m1_cmd_valid_i (m1_cmd_valid),
        .m1_cmd_ready_o (m1_cmd_ready),
        .m1_cmd_addr_i  (m1_cmd_addr),
        .m1_cmd_read_i  (m1_cmd_read),
        .m1_cmd_wdata_i (m1_cmd_wdata),
        .m1_cmd_wmask_i (m1_cmd_wmask),
        .m1_rsp_valid_o (m1_rsp_valid),
        .m1_rsp_ready_i (m1_rsp_ready),
        .m1_rsp_rdata_o (m1_rsp_rdata),
        .ram_sd_o       (ram_sd),
        .ram_ds_o       (ram_ds),
        .ram_ls_o       (ram_ls),
        .ram_cs_o       (ram_cs),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wem_o      (ram_wem),
        .ram_din_o      (ram_din),
        .ram_dout_i     (ram_dout)
    );

    // Behavioural SRAM: byte-masked write, one-cycle registered read, optional override.
    logic [DW-1:0] mem [0:(1<<RAM_AW)-1];
    logic [DW-1:0] dout_q;
    logic          ovr_en;
    logic [DW-1:0] ovr_val;
    assign ram_dout = ovr_en ? ovr_val : dout_q;

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = '0;
        dout_q = '0;
    end

    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end
        if (ram_cs && !ram_we) dout_q <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic rd, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a;
        m0_cmd_wdata = d; m0_cmd_wmask = m;
    endtask

    task automatic set_m1(input logic v, input logic rd, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a;
        m1_cmd_wdata = d; m1_cmd_wmask = m;
    endtask

    typedef struct {
        logic        m0v, m0rd;
        logic [15:0] m0a;
        logic [31:0] m0d;
        logic [3:0]  m0m;
        logic        m1v, m1rd;
        logic [15:0] m1a;
        logic [31:0] m1d;
        logic [3:0]  m1m;
        logic        cs, we;
        logic [13:0] addr;
        logic [3:0]  wem;
        logic [31:0] din;
        logic        r0, r1, v0, v1;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bit seen;

        // Inputs | expected ram strobes | cmd readies, rsp valids, rdata of valid port.
        vecs[0]  = '{0,0,16'h0,32'h0,4'h0, 0,0,16'h0,32'h0,4'h0,
                     0,0,14'd0,4'h0,32'h0, 0,0,0,0,32'h0};
        vecs[1]  = '{1,0,16'h10,32'hDEADBEEF,4'hF, 0,0,16'h0,32'h0,4'h0,
                     1,1,14'd4,4'hF,32'hDEADBEEF, 1,0,0,0,32'h0};
        vecs[2]  = '{1,1,16'h10,32'h0,4'h0, 0,0,16'h0,32'h0,4'h0,
                     1,0,14'd4,4'h0,32'h0, 1,0,1,0,32'h0};
        vecs[3]  = '{0,0,16'h0,32'h0,4'h0, 0,0,16'h0,32'h0,4'h0,
                     0,0,14'd0,4'h0,32'h0, 0,0,1,0,32'hDEADBEEF};
        vecs[4]  = '{0,0,16'h0,32'h0,4'h0, 1,0,16'h20,32'hAABBCCDD,4'hF,
                     1,1,14'd8,4'hF,32'hAABBCCDD, 0,1,0,0,32'h0};
        vecs[5]  = '{0,0,16'h0,32'h0,4'h0, 1,0,16'h20,32'h11223344,4'h5,
                     1,1,14'd8,4'h5,32'h11223344, 0,1,0,1,32'h0};
        vecs[6]  = '{0,0,16'h0,32'h0,4'h0, 1,1,16'h20,32'h0,4'h0,
                     1,0,14'd8,4'h0,32'h0, 0,1,0,1,32'h0};
        vecs[7]  = '{0,0,16'h0,32'h0,4'h0, 0,0,16'h0,32'h0,4'h0,
                     0,0,14'd0,4'h0,32'h0, 0,0,0,1,32'hAA22CC44};
        vecs[8]  = '{1,1,16'h10,32'h0,4'h0, 1,1,16'h20,32'h0,4'h0,
                     1,0,14'd4,4'h0,32'h0, 1,0,0,0,32'h0};
        vecs[9]  = '{1,1,16'h10,32'h0,4'h0, 1,1,16'h20,32'h0,4'h0,
                     1,0,14'd8,4'h0,32'h0, 0,1,1,0,32'hDEADBEEF};
        vecs[10] = '{1,1,16'h10,32'h0,4'h0, 1,1,16'h20,32'h0,4'h0,
                     1,0,14'd4,4'h0,32'h0, 1,0,0,1,32'hAA22CC44};
        vecs[11] = '{1,1,16'h10,32'h0,4'h0, 1,1,16'h20,32'h0,4'h0,
                     1,0,14'd8,4'h0,32'h0, 0,1,1,0,32'hDEADBEEF};
        vecs[12] = '{0,0,16'h0,32'h0,4'h0, 0,0,16'h0,32'h0,4'h0,
                     0,0,14'd0,4'h0,32'h0, 0,0,0,1,32'hAA22CC44};

        // Reset state, with a request pending to show no strobe leaks out.
        rst_n = 1'b0; lp_en = 1'b0; ovr_en = 1'b0; ovr_val = '0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        set_m0(1, 1, 16'h10, 32'h0, 4'h0);
        set_m1(0, 0, 16'h0, 32'h0, 4'h0);
        #2;
        check("rst cs", 32'(ram_cs), 32'd0);
        check("rst ls", 32'(ram_ls), 32'd0);
        check("rst sd_ds", 32'({ram_sd, ram_ds}), 32'd0);
        check("rst m0_ready", 32'(m0_cmd_ready), 32'd0);
        check("rst rsp_valid", 32'({m0_rsp_valid, m1_rsp_valid}), 32'd0);
        set_m0(0, 0, 16'h0, 32'h0, 4'h0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            set_m0(vecs[i].m0v, vecs[i].m0rd, vecs[i].m0a, vecs[i].m0d, vecs[i].m0m);
            set_m1(vecs[i].m1v, vecs[i].m1rd, vecs[i].m1a, vecs[i].m1d, vecs[i].m1m);
            #1;
            check($sformatf("v%0d cs", i), 32'(ram_cs), 32'(vecs[i].cs));
            check($sformatf("v%0d we", i), 32'(ram_we), 32'(vecs[i].we));
            check($sformatf("v%0d addr", i), 32'(ram_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d wem", i), 32'(ram_wem), 32'(vecs[i].wem));
            check($sformatf("v%0d din", i), ram_din, vecs[i].din);
            check($sformatf("v%0d m0_ready", i), 32'(m0_cmd_ready), 32'(vecs[i].r0));
            check($sformatf("v%0d m1_ready", i), 32'(m1_cmd_ready), 32'(vecs[i].r1));
            check($sformatf("v%0d m0_rsp_valid", i), 32'(m0_rsp_valid), 32'(vecs[i].v0));
            check($sformatf("v%0d m1_rsp_valid", i), 32'(m1_rsp_valid), 32'(vecs[i].v1));
            if (vecs[i].v0) check($sformatf("v%0d m0_rdata", i), m0_rsp_rdata, vecs[i].rdata);
            if (vecs[i].v1) check($sformatf("v%0d m1_rdata", i), m1_rsp_rdata, vecs[i].rdata);
            tick();
        end

        // Backpressure: m0 read stalls 3 cycles while the SRAM output wanders.
        set_m0(1, 1, 16'h10, 32'h0, 4'h0);
        m0_rsp_ready = 1'b0;
        #1;
        check("bp accept cs", 32'(ram_cs), 32'd1);
        check("bp accept addr", 32'(ram_addr), 32'd4);
        tick();
        set_m1(1, 1, 16'h20, 32'h0, 4'h0);
        #1;
        check("bp n1 valid", 32'(m0_rsp_valid), 32'd1);
        check("bp n1 rdata", m0_rsp_rdata, 32'hDEADBEEF);
        check("bp n1 readies", 32'({m1_cmd_ready, m0_cmd_ready}), 32'd0);
        check("bp n1 cs", 32'(ram_cs), 32'd0);
        tick();
        ovr_en = 1'b1;
        for (int j = 0; j < 2; j++) begin
            ovr_val = 32'h1234_0000 + 32'(j);
            #1;
            check($sformatf("bp hold%0d rdata", j), m0_rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp hold%0d valid", j), 32'(m0_rsp_valid), 32'd1);
            check($sformatf("bp hold%0d readies", j),
                  32'({m1_cmd_ready, m0_cmd_ready}), 32'd0);
            tick();
        end
        m0_rsp_ready = 1'b1;
        #1;
        check("bp release rdata", m0_rsp_rdata, 32'hDEADBEEF);
        check("bp release readies", 32'({m1_cmd_ready, m0_cmd_ready}), 32'b10);
        check("bp release cs", 32'(ram_cs), 32'd1);
        check("bp release addr", 32'(ram_addr), 32'd8);
        ovr_en = 1'b0;
        tick();
        set_m0(0, 0, 16'h0, 32'h0, 4'h0);
        set_m1(0, 0, 16'h0, 32'h0, 4'h0);
        #1;
        check("bp next m1 valid", 32'(m1_rsp_valid), 32'd1);
        check("bp next m1 rdata", m1_rsp_rdata, 32'hAA22CC44);
        check("bp next m0 valid", 32'(m0_rsp_valid), 32'd0);
        tick();

        // Light sleep after 16 idle cycles, then a 2-cycle wake on an m1 request.
        lp_en = 1'b1;
        set_m0(1, 0, 16'h30, 32'h55, 4'hF);
        #1;
        check("ls write cs", 32'(ram_cs), 32'd1);
        tick();
        set_m0(0, 0, 16'h0, 32'h0, 4'h0);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            k++;
            #1;
            if (ram_ls) seen = 1'b1;
            else tick();
        end
        check("ls entry cycle", 32'(k), 32'd17);
        set_m1(1, 1, 16'h20, 32'h0, 4'h0);
        #1;
        check("sleep ls", 32'(ram_ls), 32'd1);
        check("sleep m1_ready", 32'(m1_cmd_ready), 32'd0);
        check("sleep cs", 32'(ram_cs), 32'd0);
        tick();
        #1;
        check("wake ls", 32'(ram_ls), 32'd0);
        check("wake m1_ready", 32'(m1_cmd_ready), 32'd0);
        check("wake cs", 32'(ram_cs), 32'd0);
        tick();
        #1;
        check("woke m1_ready", 32'(m1_cmd_ready), 32'd1);
        check("woke cs", 32'(ram_cs), 32'd1);
        check("woke addr", 32'(ram_addr), 32'd8);
        tick();
        set_m1(0, 0, 16'h0, 32'h0, 4'h0);
        #1;
        check("woke rsp valid", 32'(m1_rsp_valid), 32'd1);
        check("woke rsp rdata", m1_rsp_rdata, 32'hAA22CC44);
        lp_en = 1'b0;
        tick();

        // Reset pulled during the response cycle of a read.
        set_m0(1, 1, 16'h10, 32'h0, 4'h0);
        #1;
        check("rmid accept cs", 32'(ram_cs), 32'd1);
        tick();
        #1;
        check("rmid rsp valid", 32'(m0_rsp_valid), 32'd1);
        check("rmid b2b cs", 32'(ram_cs), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid rst rsp valid", 32'(m0_rsp_valid), 32'd0);
        check("rmid rst cs", 32'(ram_cs), 32'd0);
        check("rmid rst ls", 32'(ram_ls), 32'd0);
        check("rmid rst m0_ready", 32'(m0_cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post rst cs", 32'(ram_cs), 32'd1);
        check("post rst m0_ready", 32'(m0_cmd_ready), 32'd1);
        check("post rst addr", 32'(ram_addr), 32'd4);
        tick();
        set_m0(0, 0, 16'h0, 32'h0, 4'h0);
        #1;
        check("post rst rsp valid", 32'(m0_rsp_valid), 32'd1);
        check("post rst rdata", m0_rsp_rdata, 32'hDEADBEEF);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
